// File: rtl/unit_align_seq.sv
// -----------------------------------------------------------------------------
// unit_align_seq
// Sequential exponent-alignment stage for the FPU add/sub path. Orders the two
// unpacked operands by magnitude and shifts the smaller mantissa right by the
// exponent difference, at most STEP bits per cycle. Guard/round/sticky bits are
// collected so the adder and normalizer see the 28-bit {carry, mant, G, R, S}
// format.
//
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_valid / o_ready          upstream handshake (o_ready high only in IDLE)
//   i_exp_a, i_mant_a          operand A (biased exponent, mantissa with hidden bit)
//   i_exp_b, i_mant_b          operand B
//   o_valid / i_ready          downstream handshake
//   o_exp                      larger exponent
//   o_mant_big                 larger operand {1'b0, mant, 3'b000}
//   o_mant_small               aligned smaller operand {carry, mant, G, R, S}
//   o_swap                     1 when B was chosen as the larger operand
//   o_busy                     block holds a transaction
// -----------------------------------------------------------------------------
module unit_align_seq #(
  parameter int STEP = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [7:0]  i_exp_a,
  input  logic [23:0] i_mant_a,
  input  logic [7:0]  i_exp_b,
  input  logic [23:0] i_mant_b,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [7:0]  o_exp,
  output logic [27:0] o_mant_big,
  output logic [27:0] o_mant_small,
  output logic        o_swap,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] STEP_W     = 5'(STEP);
  localparam logic [7:0] COLLAPSE_D = 8'd26;

  state_t      state_q, state_d;
  logic [4:0]  rem_q, rem_d;
  logic        valid_q, valid_d;
  logic        swap_q, swap_d;
  logic [7:0]  exp_q, exp_d;
  logic [27:0] big_q, big_d;
  logic [27:0] small_q, small_d;

  logic        a_big;
  logic        special;
  logic [7:0]  diff;
  logic [7:0]  exp_l;
  logic [23:0] mant_l;
  logic [23:0] mant_s;
  logic [4:0]  step;
  logic [4:0]  rem_next;

  // Right shift by s with every bit that falls off (old bit0 included) ORed
  // into the new bit0, so sticky information survives multi-cycle shifting.
  function automatic logic [27:0] shr_sticky(input logic [27:0] v, input logic [4:0] s);
    logic [27:0] mask;
    logic [27:0] r;
    mask = (28'd1 << s) - 28'd1;
    r    = v >> s;
    r[0] = r[0] | (|(v & mask));
    return r;
  endfunction

  // Operand ordering: compare exponents, break ties on mantissa (A wins ties).
  always_comb begin
    a_big   = (i_exp_a > i_exp_b) || ((i_exp_a == i_exp_b) && (i_mant_a >= i_mant_b));
    special = (i_exp_a == 8'hFF) || (i_exp_b == 8'hFF);
    diff    = a_big ? (i_exp_a - i_exp_b) : (i_exp_b - i_exp_a);
    exp_l   = a_big ? i_exp_a  : i_exp_b;
    mant_l  = a_big ? i_mant_a : i_mant_b;
    mant_s  = a_big ? i_mant_b : i_mant_a;
  end

  always_comb begin
    step     = (rem_q < STEP_W) ? rem_q : STEP_W;
    rem_next = rem_q - step;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    swap_d  = swap_q;
    exp_d   = exp_q;
    big_d   = big_q;
    small_d = small_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          exp_d  = exp_l;
          big_d  = {1'b0, mant_l, 3'b000};
          swap_d = ~a_big;
          if (special) begin
            // Inf/NaN operands bypass alignment entirely.
            small_d = {1'b0, mant_s, 3'b000};
            rem_d   = 5'd0;
          end else if (diff >= COLLAPSE_D) begin
            // Everything lands below the sticky position.
            small_d = {27'd0, |mant_s};
            rem_d   = 5'd0;
          end else begin
            small_d = {1'b0, mant_s, 3'b000};
            rem_d   = diff[4:0];
          end
          state_d = (!special && diff < COLLAPSE_D && diff != 8'd0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        small_d = shr_sticky(small_q, step);
        rem_d   = rem_next;
        if (rem_next == 5'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // o_valid lags entry into DONE by one edge.
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rem_q   <= 5'd0;
      valid_q <= 1'b0;
      swap_q  <= 1'b0;
      exp_q   <= 8'd0;
      big_q   <= 28'd0;
      small_q <= 28'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      swap_q  <= swap_d;
      exp_q   <= exp_d;
      big_q   <= big_d;
      small_q <= small_d;
    end
  end

  assign o_ready      = (state_q == IDLE);
  assign o_busy       = (state_q != IDLE);
  assign o_valid      = valid_q;
  assign o_swap       = swap_q;
  assign o_exp        = exp_q;
  assign o_mant_big   = big_q;
  assign o_mant_small = small_q;

endmodule

// File: tb/tb_unit_align_seq.sv
// -----------------------------------------------------------------------------
// tb_unit_align_seq
// Directed and randomized transactions against unit_align_seq (STEP=4), with
// expected results computed from the alignment rules by a one-shot arithmetic
// model: single full-distance shift with sticky from all discarded bits.
// -----------------------------------------------------------------------------
module tb_unit_align_seq;

  localparam int STEP = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_exp_a;
  logic [23:0] i_mant_a;
  logic [7:0]  i_exp_b;
  logic [23:0] i_mant_b;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_exp;
  logic [27:0] o_mant_big;
  logic [27:0] o_mant_small;
  logic        o_swap;
  logic        o_busy;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  unit_align_seq #(.STEP(STEP)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_exp_a      (i_exp_a),
    .i_mant_a     (i_mant_a),
    .i_exp_b      (i_exp_b),
    .i_mant_b     (i_mant_b),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_exp        (o_exp),
    .o_mant_big   (o_mant_big),
    .o_mant_small (o_mant_small),
    .o_swap       (o_swap),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: order by magnitude ({exp,mant} as one unsigned number), then a
  // single full-distance shift of the smaller operand.
  task automatic model(input logic [7:0] ea, input logic [23:0] ma,
                       input logic [7:0] eb, input logic [23:0] mb,
                       output logic [7:0] e_exp, output logic [27:0] e_big,
                       output logic [27:0] e_small, output logic e_swap,
                       output int e_n);
    longint full, mask, sh;
    int d;
    logic [23:0] ms;
    if ({ea, ma} >= {eb, mb}) begin
      e_swap = 1'b0; e_exp = ea; e_big = {1'b0, ma, 3'b000}; ms = mb; d = int'(ea) - int'(eb);
    end else begin
      e_swap = 1'b1; e_exp = eb; e_big = {1'b0, mb, 3'b000}; ms = ma; d = int'(eb) - int'(ea);
    end
    full = longint'(ms) * 8;
    if (ea == 8'hFF || eb == 8'hFF) begin
      e_small = 28'(full);
      e_n     = 0;
    end else if (d >= 26) begin
      e_small = (ms != 24'd0) ? 28'd1 : 28'd0;
      e_n     = 0;
    end else begin
      mask = (longint'(1) << d) - 1;
      sh   = full >> d;
      if ((full & mask) != 0) sh = sh | 1;
      e_small = 28'(sh);
      e_n     = (d + STEP - 1) / STEP;
    end
  endtask

  task automatic run_txn(input string tag, input logic [7:0] ea, input logic [23:0] ma,
                         input logic [7:0] eb, input logic [23:0] mb, input int hold);
    logic [7:0]  e_exp;
    logic [27:0] e_big, e_small;
    logic        e_swap;
    int          e_n, lat, w;
    model(ea, ma, eb, mb, e_exp, e_big, e_small, e_swap, e_n);
    w = 0;
    while (!o_ready && w < 20) begin
      @(posedge i_clk); #1; w++;
    end
    chk({tag, ".ready"}, 32'(o_ready), 32'd1);
    i_exp_a = ea; i_mant_a = ma; i_exp_b = eb; i_mant_b = mb;
    i_valid = 1'b1;
    i_ready = 1'b0;
    @(posedge i_clk); #1;
    i_valid  = 1'b0;
    i_exp_a  = 8'($urandom); i_mant_a = 24'($urandom);
    i_exp_b  = 8'($urandom); i_mant_b = 24'($urandom);
    lat = 0;
    while (lat < 60) begin
      lat++;
      @(posedge i_clk); #1;
      if (o_valid) break;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(e_n + 1));
    chk({tag, ".exp"},   32'(o_exp),        32'(e_exp));
    chk({tag, ".big"},   32'(o_mant_big),   32'(e_big));
    chk({tag, ".small"}, 32'(o_mant_small), 32'(e_small));
    chk({tag, ".swap"},  32'(o_swap),       32'(e_swap));
    // Backpressure with fresh operands offered: must be neither accepted nor sampled.
    for (int h = 0; h < hold; h++) begin
      i_valid  = 1'b1;
      i_exp_a  = 8'($urandom); i_mant_a = 24'($urandom);
      i_exp_b  = 8'($urandom); i_mant_b = 24'($urandom);
      @(posedge i_clk); #1;
      chk({tag, ".hold_valid"}, 32'(o_valid),      32'd1);
      chk({tag, ".hold_ready"}, 32'(o_ready),      32'd0);
      chk({tag, ".hold_exp"},   32'(o_exp),        32'(e_exp));
      chk({tag, ".hold_big"},   32'(o_mant_big),   32'(e_big));
      chk({tag, ".hold_small"}, 32'(o_mant_small), 32'(e_small));
      chk({tag, ".hold_swap"},  32'(o_swap),       32'(e_swap));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".post_ready"}, 32'(o_ready), 32'd1);
    chk({tag, ".post_busy"},  32'(o_busy),  32'd0);
  endtask

  initial begin
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    int          t;

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_exp_a = 8'h0; i_mant_a = 24'h0; i_exp_b = 8'h0; i_mant_b = 24'h0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst.valid", 32'(o_valid),      32'd0);
    chk("rst.busy",  32'(o_busy),       32'd0);
    chk("rst.ready", 32'(o_ready),      32'd1);
    chk("rst.swap",  32'(o_swap),       32'd0);
    chk("rst.exp",   32'(o_exp),        32'd0);
    chk("rst.big",   32'(o_mant_big),   32'd0);
    chk("rst.small", 32'(o_mant_small), 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    run_txn("basic",    8'h85, 24'hC00000, 8'h82, 24'h800000, 0);
    chk("basic.abs_small", 32'(o_mant_small), 32'h0800000);
    run_txn("sticky",   8'h84, 24'h800000, 8'h80, 24'h800001, 0);
    chk("sticky.abs_small", 32'(o_mant_small), 32'h0400001);
    run_txn("collapse", 8'h9E, 24'h800000, 8'h80, 24'hFFFFFF, 0);
    chk("collapse.abs_small", 32'(o_mant_small), 32'h0000001);
    run_txn("eqswap",   8'h80, 24'h800000, 8'h80, 24'h900000, 0);
    chk("eqswap.abs_swap", 32'(o_swap),       32'd1);
    chk("eqswap.abs_big",  32'(o_mant_big),   32'h4800000);
    chk("eqswap.abs_small",32'(o_mant_small), 32'h4000000);
    run_txn("special",  8'h10, 24'hC00000, 8'hFF, 24'h800000, 0);
    run_txn("d25",      8'h99, 24'h800000, 8'h80, 24'hFFFFFF, 1);
    run_txn("d26",      8'h9A, 24'h800000, 8'h80, 24'hFFFFFF, 0);
    run_txn("backpr",   8'h83, 24'hA5A5A5, 8'h8A, 24'hF00001, 5);

    // Reset during the second SHIFT cycle of a d=20 transaction.
    i_exp_a = 8'h94; i_mant_a = 24'hABCDEF; i_exp_b = 8'h80; i_mant_b = 24'hFFFFFF;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk("midrst.busy_before", 32'(o_busy), 32'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("midrst.busy",  32'(o_busy),       32'd0);
    chk("midrst.ready", 32'(o_ready),      32'd1);
    chk("midrst.valid", 32'(o_valid),      32'd0);
    chk("midrst.exp",   32'(o_exp),        32'd0);
    chk("midrst.big",   32'(o_mant_big),   32'd0);
    chk("midrst.small", 32'(o_mant_small), 32'd0);
    chk("midrst.swap",  32'(o_swap),       32'd0);
    run_txn("after_rst", 8'h94, 24'hABCDEF, 8'h80, 24'hFFFFFF, 0);

    for (int k = 0; k < 40; k++) begin
      ea = 8'($urandom_range(1, 254));
      t  = int'(ea) + int'($urandom_range(0, 60)) - 30;
      if (t < 0)   t = 0;
      if (t > 254) t = 254;
      eb = 8'(t);
      if ($urandom_range(0, 9) == 0) ea = 8'hFF;
      if ($urandom_range(0, 9) == 0) eb = 8'hFF;
      ma = {1'b1, 23'($urandom)};
      mb = ($urandom_range(0, 5) == 0) ? ma : {1'b1, 23'($urandom)};
      if ($urandom_range(0, 7) == 0) eb = ea;
      run_txn("rand", ea, ma, eb, mb, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
